// File: rtl/caxi4interconnect_axi4_ahb_read_resp_pkg.sv
// Shared types and encodings for the AXI4 read to AHB-Lite single-transfer responder.
package caxi4interconnect_axi4_ahb_read_resp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StResp
  } state_e;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  localparam logic [2:0] HburstSingle = 3'b000;

endpackage

// File: rtl/caxi4interconnect_axi4_ahb_read_resp_if.sv
// AXI4 read channels plus AHB-Lite master signals; slave modport is the responder's view.
interface caxi4interconnect_axi4_ahb_read_resp_if #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 1
);

  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic [1:0]            ARLOCK;
  logic [3:0]            ARCACHE;
  logic [2:0]            ARPROT;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic [USER_WIDTH-1:0] RUSER;
  logic                  RVALID;
  logic                  RREADY;

  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic [2:0]            HBURST;
  logic [2:0]            HSIZE;
  logic                  HWRITE;
  logic [6:0]            HPROT;
  logic                  HMASTLOCK;
  logic                  HNONSEC;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HRESP;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    input  RREADY,
    output HADDR, HTRANS, HBURST, HSIZE, HWRITE, HPROT, HMASTLOCK, HNONSEC,
    input  HREADY, HRDATA, HRESP
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    output RREADY,
    input  HADDR, HTRANS, HBURST, HSIZE, HWRITE, HPROT, HMASTLOCK, HNONSEC,
    output HREADY, HRDATA, HRESP
  );

endinterface

// File: rtl/caxi4interconnect_axi4_addr_next.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts (low 32 bits wrap around).
module caxi4interconnect_axi4_addr_next
  import caxi4interconnect_axi4_ahb_read_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] addr_next
);

  logic [31:0] incr;
  logic [31:0] mask;
  logic [31:0] sum;

  always_comb begin
    incr      = 32'd1 << size;
    mask      = (({24'd0, len} + 32'd1) << size) - 32'd1;
    sum       = addr[31:0] + incr;
    addr_next = addr;
    case (burst)
      BurstFixed: addr_next[31:0] = addr[31:0];
      BurstWrap:  addr_next[31:0] = (addr[31:0] & ~mask) | (sum & mask);
      default:    addr_next[31:0] = sum;  // INCR and reserved encoding
    endcase
  end

endmodule

// File: rtl/caxi4interconnect_axi4_ahb_read_resp.sv
// AXI4 read responder: each burst beat becomes one AHB-Lite SINGLE read, returned on R.
module caxi4interconnect_axi4_ahb_read_resp
  import caxi4interconnect_axi4_ahb_read_resp_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 1
) (
  input logic ACLK,
  input logic sysReset,
  caxi4interconnect_axi4_ahb_read_resp_if.slave bus
);

  state_e state_q, state_d;

  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_nxt;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic [6:0]            hprot_q, hprot_d;
  logic                  hnonsec_q, hnonsec_d;
  logic                  hmastlock_q, hmastlock_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [1:0]            htrans_q, htrans_d;

  logic ar_hs;
  logic data_done;
  logic r_hs;
  logic unused_attr;

  assign ar_hs     = (state_q == StIdle) & bus.ARVALID;
  assign data_done = (state_q == StData) & bus.HREADY;
  assign r_hs      = (state_q == StResp) & bus.RREADY;

  caxi4interconnect_axi4_addr_next #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_next (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .addr_next (addr_nxt)
  );

  always_ff @(posedge ACLK or negedge sysReset) begin
    if (!sysReset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (ar_hs) state_d = StAddr;
      StAddr: if (bus.HREADY) state_d = StData;
      StData: if (bus.HREADY) state_d = StResp;
      StResp: begin
        if (bus.RREADY) begin
          if (rlast_q) begin
            state_d = StIdle;
          end else if (err_q) begin
            // After an AHB error the remaining beats are answered without touching AHB.
            state_d = StResp;
          end else begin
            state_d = StAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values for every registered output and the transaction context.
  always_comb begin
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    hprot_d     = hprot_q;
    hnonsec_d   = hnonsec_q;
    hmastlock_d = hmastlock_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    arready_d   = (state_d == StIdle);
    rvalid_d    = (state_d == StResp);
    htrans_d    = (state_d == StAddr) ? HtransNonseq : HtransIdle;

    if (ar_hs) begin
      id_d        = bus.ARID;
      addr_d      = bus.ARADDR;
      len_d       = bus.ARLEN;
      size_d      = bus.ARSIZE;
      burst_d     = bus.ARBURST;
      cnt_d       = 8'd0;
      err_d       = 1'b0;
      hprot_d     = {1'b0, bus.ARCACHE[3], 1'b0, bus.ARCACHE[1], bus.ARCACHE[0],
                     bus.ARPROT[0], ~bus.ARPROT[2]};
      hnonsec_d   = bus.ARPROT[1];
      hmastlock_d = bus.ARLOCK[0];
    end

    if (data_done) begin
      rdata_d = bus.HRDATA;
      rresp_d = bus.HRESP ? RespSlverr : RespOkay;
      err_d   = bus.HRESP;
      rlast_d = (cnt_q == len_q);
    end

    if (r_hs) begin
      if (rlast_q) begin
        rlast_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + 8'd1;
        addr_d = addr_nxt;
        if (err_q) begin
          rdata_d = '0;
          rresp_d = RespSlverr;
          rlast_d = (cnt_d == len_q);
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge sysReset) begin
    if (!sysReset) begin
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      hprot_q     <= '0;
      hnonsec_q   <= 1'b0;
      hmastlock_q <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RespOkay;
      rlast_q     <= 1'b0;
      arready_q   <= 1'b1;
      rvalid_q    <= 1'b0;
      htrans_q    <= HtransIdle;
    end else begin
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      hprot_q     <= hprot_d;
      hnonsec_q   <= hnonsec_d;
      hmastlock_q <= hmastlock_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rlast_q     <= rlast_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      htrans_q    <= htrans_d;
    end
  end

  assign bus.ARREADY   = arready_q;
  assign bus.RID       = id_q;
  assign bus.RDATA     = rdata_q;
  assign bus.RRESP     = rresp_q;
  assign bus.RLAST     = rlast_q;
  assign bus.RUSER     = '0;
  assign bus.RVALID    = rvalid_q;
  assign bus.HADDR     = addr_q[31:0];
  assign bus.HTRANS    = htrans_q;
  assign bus.HBURST    = HburstSingle;
  assign bus.HSIZE     = size_q;
  assign bus.HWRITE    = 1'b0;
  assign bus.HPROT     = hprot_q;
  assign bus.HMASTLOCK = hmastlock_q;
  assign bus.HNONSEC   = hnonsec_q;

  assign unused_attr = ^{bus.ARLOCK[1], bus.ARCACHE[2]};

endmodule
